// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter sharing one SRAM controller port, with in-order read tag routing
module sram_port_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 20,
    parameter int DATA_W          = 16
) (
    input  logic                               BOARD_CLK,
    input  logic                               RESET_N,
    input  logic [NUM_REQ-1:0]                 ReqValid,
    input  logic [NUM_REQ-1:0]                 ReqWrite,
    input  logic [ADDR_W-1:0]                  ReqAddr [NUM_REQ],
    input  logic [DATA_W-1:0]                  ReqData [NUM_REQ],
    output logic [NUM_REQ-1:0]                 ReqGrant,
    output logic [NUM_REQ-1:0]                 RespValid,
    output logic [DATA_W-1:0]                  RespData,
    output logic [ADDR_W-1:0]                  AddressToSRAM,
    output logic [DATA_W-1:0]                  DataToSRAM,
    output logic                               QueueReadReq,
    output logic                               QueueWriteReq,
    input  logic                               PortReady,
    input  logic                               PortRespValid,
    input  logic [DATA_W-1:0]                  PortRespData,
    output logic [$clog2(MAX_OUTSTANDING):0]   Outstanding,
    output logic                               OrphanError
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [ID_W-1:0]  prio_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  next_ptr;
    logic             grant_any;
    logic             grant_write;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic [ID_W-1:0]  tag_mem [2**PTR_W];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign pop = PortRespValid && (Outstanding != '0);
    // Fullness is judged after this cycle's pop so a read can slip in behind a returning response.
    assign fifo_full = (Outstanding == CNT_W'(MAX_OUTSTANDING)) && !pop;

    always_comb begin
        int             idx;
        logic [ID_W-1:0] cand;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(prio_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (!grant_any && ReqValid[cand] && PortReady && (ReqWrite[cand] || !fifo_full)) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    assign grant_write = ReqWrite[grant_id];
    assign push        = RESET_N && grant_any && !grant_write;
    assign next_ptr    = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    always_comb begin
        ReqGrant = '0;
        if (RESET_N && grant_any) ReqGrant[grant_id] = 1'b1;
    end

    always_ff @(posedge BOARD_CLK) begin
        if (push) tag_mem[wr_ptr] <= grant_id;
    end

    always_ff @(posedge BOARD_CLK) begin
        if (!RESET_N) begin
            prio_ptr      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            Outstanding   <= '0;
            QueueReadReq  <= 1'b0;
            QueueWriteReq <= 1'b0;
            AddressToSRAM <= '0;
            DataToSRAM    <= '0;
            RespValid     <= '0;
            RespData      <= '0;
            OrphanError   <= 1'b0;
        end else begin
            QueueReadReq  <= grant_any && !grant_write;
            QueueWriteReq <= grant_any && grant_write;
            if (grant_any) begin
                AddressToSRAM <= ReqAddr[grant_id];
                DataToSRAM    <= ReqData[grant_id];
                prio_ptr      <= next_ptr;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            RespValid <= '0;
            if (pop) begin
                RespValid[tag_mem[rd_ptr]] <= 1'b1;
                RespData                   <= PortRespData;
                rd_ptr                     <= rd_ptr + 1'b1;
            end
            if (PortRespValid && Outstanding == '0) OrphanError <= 1'b1;
            case ({push, pop})
                2'b10:   Outstanding <= Outstanding + 1'b1;
                2'b01:   Outstanding <= Outstanding - 1'b1;
                default: Outstanding <= Outstanding;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid, req_write, req_grant, resp_valid;
    logic [19:0] req_addr [4];
    logic [15:0] req_data [4];
    logic [15:0] resp_data, port_resp_data, data_to_sram;
    logic [19:0] addr_to_sram;
    logic        q_rd, q_wr, port_ready, port_resp_valid, orphan;
    logic [2:0]  outstanding;

    sram_port_arbiter dut (
        .BOARD_CLK(clk), .RESET_N(rst_n),
        .ReqValid(req_valid), .ReqWrite(req_write), .ReqAddr(req_addr), .ReqData(req_data),
        .ReqGrant(req_grant), .RespValid(resp_valid), .RespData(resp_data),
        .AddressToSRAM(addr_to_sram), .DataToSRAM(data_to_sram),
        .QueueReadReq(q_rd), .QueueWriteReq(q_wr), .PortReady(port_ready),
        .PortRespValid(port_resp_valid), .PortRespData(port_resp_data),
        .Outstanding(outstanding), .OrphanError(orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit w; logic [19:0] addr; logic [15:0] data; int due; } issue_t;
    typedef struct { int id; logic [15:0] data; int due; } resp_t;

    issue_t issue_q[$];
    resp_t  resp_q[$];
    int     tag_q[$];
    int     checks = 0, failures = 0;
    int     cyc = 0, m_ptr = 0, last_grant = -1;
    bit     m_orphan = 0, mon_en = 0;
    issue_t ie;
    resp_t  re;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: pop expectations that fall due this cycle, otherwise demand idle strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (issue_q.size() > 0 && issue_q[0].due == cyc) begin
                ie = issue_q.pop_front();
                if (q_wr !== ie.w || q_rd !== !ie.w || addr_to_sram !== ie.addr || data_to_sram !== ie.data) begin
                    failures++;
                    $display("FAIL issue cyc=%0d got wr=%b rd=%b a=%h d=%h want wr=%b a=%h d=%h",
                             cyc, q_wr, q_rd, addr_to_sram, data_to_sram, ie.w, ie.addr, ie.data);
                end
            end else if (q_wr !== 1'b0 || q_rd !== 1'b0) begin
                failures++;
                $display("FAIL spurious_pulse cyc=%0d got wr=%b rd=%b want 0 0", cyc, q_wr, q_rd);
            end
            checks++;
            if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
                re = resp_q.pop_front();
                if (resp_valid !== 4'(1 << re.id) || resp_data !== re.data) begin
                    failures++;
                    $display("FAIL resp cyc=%0d got v=%b d=%h want v=%b d=%h",
                             cyc, resp_valid, resp_data, 4'(1 << re.id), re.data);
                end
            end else if (resp_valid !== 4'b0) begin
                failures++;
                $display("FAIL spurious_resp cyc=%0d got %b want 0000", cyc, resp_valid);
            end
        end
    end

    // One clock: predict the grant, compare it, and push the resulting expectations.
    task automatic cycle();
        int  g, idx;
        bit  pop, full;
        logic [3:0] exp_g;
        @(negedge clk);
        g = -1;
        if (rst_n) begin
            pop  = port_resp_valid && tag_q.size() > 0;
            full = (tag_q.size() == 4) && !pop;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (g < 0 && req_valid[idx] && port_ready && (req_write[idx] || !full)) g = idx;
            end
        end
        exp_g = (g >= 0) ? 4'(1 << g) : 4'b0;
        checks++;
        if (req_grant !== exp_g) begin
            failures++;
            $display("FAIL grant cyc=%0d got %b want %b", cyc, req_grant, exp_g);
        end
        last_grant = g;
        if (rst_n) begin
            if (port_resp_valid) begin
                if (tag_q.size() > 0) resp_q.push_back('{tag_q.pop_front(), port_resp_data, cyc + 1});
                else m_orphan = 1;
            end
            if (g >= 0) begin
                issue_q.push_back('{req_write[g], req_addr[g], req_data[g], cyc + 1});
                if (!req_write[g]) tag_q.push_back(g);
                m_ptr = (g + 1) % 4;
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            issue_q.delete(); resp_q.delete(); tag_q.delete();
            m_ptr = 0; m_orphan = 0;
        end
        checks++;
        if (outstanding !== 3'(tag_q.size()) || orphan !== m_orphan) begin
            failures++;
            $display("FAIL state cyc=%0d got out=%0d orphan=%b want out=%0d orphan=%b",
                     cyc, outstanding, orphan, tag_q.size(), m_orphan);
        end
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_write = '0; port_resp_valid = 0; port_resp_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = 4'hF; req_write = 4'b0101; port_ready = 1;
        port_resp_valid = 1; port_resp_data = 16'h5A5A;
        for (int i = 0; i < 4; i++) begin req_addr[i] = 20'(i + 1); req_data[i] = 16'(i + 9); end
        cycle();
        cycle();
        checks++;
        if (req_grant !== 4'b0) begin failures++; $display("FAIL reset_grant got %b want 0000", req_grant); end
        checks++;
        if (addr_to_sram !== '0 || data_to_sram !== '0 || resp_data !== '0 || q_rd !== 0 || q_wr !== 0) begin
            failures++;
            $display("FAIL reset_outputs got a=%h d=%h rd=%h qr=%b qw=%b want all 0",
                     addr_to_sram, data_to_sram, resp_data, q_rd, q_wr);
        end
        checks++;
        if (outstanding !== 3'd0 || orphan !== 1'b0 || resp_valid !== 4'b0) begin
            failures++;
            $display("FAIL reset_state got out=%0d orphan=%b rv=%b want 0 0 0000", outstanding, orphan, resp_valid);
        end
        idle_inputs();
        rst_n = 1;
        cycle();
    endtask

    task automatic test_back_to_back();
        int seq[5];
        int want[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin req_addr[i] = 20'h100 * (i + 1); req_data[i] = 16'hC000 + 16'(i); end
        req_valid = 4'hF; req_write = 4'hF;
        for (int i = 0; i < 5; i++) begin cycle(); seq[i] = last_grant; end
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (seq[i] !== want[i]) begin
                failures++;
                $display("FAIL b2b_order slot=%0d got %0d want %0d", i, seq[i], want[i]);
            end
        end
        cycle();
    endtask

    task automatic test_routing();
        req_valid = 4'b0100; req_write = 4'b0; req_addr[2] = 20'h00010;
        cycle();
        checks++;
        if (last_grant !== 2) begin failures++; $display("FAIL route_grant2 got %0d want 2", last_grant); end
        req_valid = 4'b0001; req_addr[0] = 20'h00020;
        cycle();
        req_valid = '0;
        port_resp_valid = 1; port_resp_data = 16'hAAAA;
        cycle();
        checks++;
        if (resp_valid !== 4'b0100 || resp_data !== 16'hAAAA) begin
            failures++; $display("FAIL route_first got v=%b d=%h want 0100 aaaa", resp_valid, resp_data);
        end
        port_resp_data = 16'hBBBB;
        cycle();
        checks++;
        if (resp_valid !== 4'b0001 || resp_data !== 16'hBBBB) begin
            failures++; $display("FAIL route_second got v=%b d=%h want 0001 bbbb", resp_valid, resp_data);
        end
        idle_inputs();
        cycle();
        checks++;
        if (resp_valid !== 4'b0 || resp_data !== 16'hBBBB) begin
            failures++; $display("FAIL route_hold got v=%b d=%h want 0000 bbbb", resp_valid, resp_data);
        end
    endtask

    task automatic test_fifo_full();
        req_valid = 4'b0001; req_write = 4'b0;
        for (int i = 0; i < 4; i++) begin req_addr[0] = 20'h300 + 20'(i); cycle(); end
        checks++;
        if (outstanding !== 3'd4) begin failures++; $display("FAIL full_count got %0d want 4", outstanding); end
        req_valid = 4'b0010; req_addr[1] = 20'h00400;
        cycle();
        checks++;
        if (last_grant !== -1) begin failures++; $display("FAIL full_block got %0d want -1", last_grant); end
        req_valid = 4'b1010; req_write = 4'b1000; req_addr[3] = 20'h00500; req_data[3] = 16'h3333;
        cycle();
        checks++;
        if (last_grant !== 3) begin failures++; $display("FAIL full_write got %0d want 3", last_grant); end
        req_valid = 4'b0010; req_write = 4'b0; port_resp_valid = 1; port_resp_data = 16'h1111;
        cycle();
        checks++;
        if (last_grant !== 1 || outstanding !== 3'd4) begin
            failures++; $display("FAIL full_swap got g=%0d out=%0d want g=1 out=4", last_grant, outstanding);
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin port_resp_data = 16'h2000 + 16'(i); cycle(); end
        idle_inputs();
        cycle();
        checks++;
        if (outstanding !== 3'd0) begin failures++; $display("FAIL full_drain got %0d want 0", outstanding); end
    endtask

    task automatic test_backpressure();
        int grants = 0;
        port_ready = 0; req_valid = 4'hF; req_write = 4'hF;
        for (int i = 0; i < 5; i++) begin cycle(); if (last_grant >= 0) grants++; end
        checks++;
        if (grants !== 0) begin failures++; $display("FAIL bp_grants got %0d want 0", grants); end
        port_ready = 1;
        cycle();
        checks++;
        if (last_grant !== 2) begin failures++; $display("FAIL bp_pointer got %0d want 2", last_grant); end
        idle_inputs();
        cycle();
    endtask

    task automatic test_orphan();
        rst_n = 0; cycle(); rst_n = 1;
        port_resp_valid = 1; port_resp_data = 16'hDEAD;
        cycle();
        port_resp_valid = 0;
        checks++;
        if (orphan !== 1'b1 || resp_valid !== 4'b0) begin
            failures++; $display("FAIL orphan_set got e=%b v=%b want 1 0000", orphan, resp_valid);
        end
        repeat (3) cycle();
        checks++;
        if (orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got %b want 1", orphan); end
        rst_n = 0; cycle(); rst_n = 1;
        checks++;
        if (orphan !== 1'b0) begin failures++; $display("FAIL orphan_clear got %b want 0", orphan); end
        cycle();
    endtask

    task automatic test_mid_reset();
        req_write = 4'b0;
        req_valid = 4'b0001; req_addr[0] = 20'h00700; cycle();
        req_valid = 4'b0010; req_addr[1] = 20'h00800; cycle();
        req_valid = '0;
        checks++;
        if (outstanding !== 3'd2) begin failures++; $display("FAIL mid_before got %0d want 2", outstanding); end
        rst_n = 0; cycle(); rst_n = 1;
        checks++;
        if (outstanding !== 3'd0 || addr_to_sram !== '0 || q_rd !== 0 || resp_data !== '0) begin
            failures++; $display("FAIL mid_reset got out=%0d a=%h qr=%b rd=%h want 0", outstanding, addr_to_sram, q_rd, resp_data);
        end
        port_resp_valid = 1; port_resp_data = 16'h7777;
        cycle();
        idle_inputs();
        checks++;
        if (orphan !== 1'b1 || resp_valid !== 4'b0) begin
            failures++; $display("FAIL mid_orphan got e=%b v=%b want 1 0000", orphan, resp_valid);
        end
        cycle();
    endtask

    initial begin
        rst_n = 0; port_ready = 1;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin req_addr[i] = '0; req_data[i] = '0; end
        test_reset();
        mon_en = 1;
        test_back_to_back();
        test_routing();
        test_fifo_full();
        test_backpressure();
        test_orphan();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one SRAM_controller request port among NUM_REQ BOARD_CLK-domain requesters (rasterizer, texture fetch, scanout prefetch, CPU bridge). It grants requests round-robin, issues single-cycle read/write queue pulses to the controller port, and records the requester ID of every read in an in-order tag FIFO. Read data returning from the port is then routed back to the requester that issued it.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MAX_OUTSTANDING, 4, depth of read tag FIFO (power of 2)
- ADDR_W, 20, address width
- DATA_W, 16, data width

Ports:
- BOARD_CLK  in  1  sole clock; one clock, reset is synchronous and active-low
- RESET_N  in  1  synchronous active-low reset
- ReqValid[NUM_REQ]  in  1 each  requester holds request
- ReqWrite[NUM_REQ]  in  1 each  1 = write, 0 = read
- ReqAddr[NUM_REQ]  in  ADDR_W each  request address
- ReqData[NUM_REQ]  in  DATA_W each  write data
- ReqGrant[NUM_REQ]  out  1 each  combinational accept strobe
- RespValid[NUM_REQ]  out  1 each  one-cycle read-data strobe
- RespData  out  DATA_W  read data, shared by all requesters
- AddressToSRAM  out  ADDR_W  to controller port
- DataToSRAM  out  DATA_W  to controller port
- QueueReadReq, QueueWriteReq  out  1  one-cycle enqueue pulses
- PortReady  in  1  controller port FIFO can accept an entry
- PortRespValid  in  1  one-cycle pulse, in-order read data valid
- PortRespData  in  DATA_W  read data
- Outstanding  out  clog2(MAX_OUTSTANDING)+1  reads in flight
- OrphanError  out  1  sticky: response arrived with empty tag FIFO

## Operation
- Handshake: requester asserts ReqValid and holds ReqWrite, ReqAddr, ReqData stable until ReqGrant pulses in the same cycle. It may drop ReqValid the cycle after the grant.
- Eligibility: requester i is eligible iff ReqValid[i] && PortReady && (ReqWrite[i] || tag FIFO not full).
- Arbitration:
  - Priority pointer P (0..NUM_REQ-1) starts at 0.
  - The grant goes to the first eligible index scanning P, P+1, … modulo NUM_REQ (wrap-around).
  - At most one grant per cycle (one-hot or zero).
  - On a grant to i, P <= (i+1) mod NUM_REQ. With no grant, P holds.
- Issue: on a grant, the next cycle drives AddressToSRAM/DataToSRAM with the granted requester's fields. QueueWriteReq or QueueReadReq pulses for exactly one cycle. Otherwise both pulses are 0 and the address/data outputs hold their last values.
- Tag FIFO:
  - A read grant pushes ID i in the grant cycle.
  - PortRespValid pops the head ID h. The next cycle, RespValid[h]=1 and RespData=PortRespData.
  - RespData holds its value between responses.
- Simultaneous push and pop in one cycle: both happen and Outstanding is unchanged. A read may be granted when the FIFO is full only if a pop occurs that same cycle; full is evaluated after the pop.
- Outstanding: push +1, pop −1, both 0. It never exceeds MAX_OUTSTANDING.
- Orphan response (PortRespValid with FIFO empty): data is dropped, no RespValid is raised, and OrphanError is set to 1 until reset.
- Writes never touch the tag FIFO. Ordering between writes and reads is the controller's responsibility.

## Timing
- Reset (RESET_N=0 at a BOARD_CLK edge):
  - ReqGrant=0, RespValid=0, QueueReadReq=0, QueueWriteReq=0.
  - AddressToSRAM=0, DataToSRAM=0, RespData=0, Outstanding=0, OrphanError=0.
  - P=0 and the FIFO is empty.
  - ReqGrant is also forced to 0 combinationally while RESET_N=0.
- Grant → queue pulse: 1 cycle.
- PortRespValid → RespValid: 1 cycle.
- Throughput: 1 request per cycle while PortReady=1.
- PortReady is sampled combinationally in the grant cycle. A PortReady drop blocks new grants but never cancels a pulse already registered.
- Reset mid-operation: in-flight tags are discarded. Later responses for those tags are treated as orphans and set OrphanError.

## Test plan
- Back-to-back grants: requesters 0..3 all request continuously, PortReady=1 → grants cycle 0,1,2,3,0 with one queue pulse per cycle, each 1 cycle after its grant.
- Read-data routing: requester 2 reads 0x00010, then requester 0 reads 0x00020. PortRespValid returns 0xAAAA then 0xBBBB → RespValid[2] with 0xAAAA, then RespValid[0] with 0xBBBB, each 1 cycle after its PortRespValid.
- Tag FIFO full: 4 reads outstanding, requester 1 read pending → no grant. A PortRespValid in cycle N grants requester 1 in cycle N and Outstanding stays 4. A write from requester 3 is still granted while full.
- Backpressure: PortReady=0 for 5 cycles with all requesters valid → zero grants and zero pulses. Priority pointer unchanged after PortReady returns.
- Orphan response: PortRespValid after reset with Outstanding=0 → no RespValid, OrphanError=1 until RESET_N=0.
- Mid-operation reset: 2 reads outstanding, assert RESET_N=0 for 1 cycle → all outputs take reset values and Outstanding=0.
